// File: rtl/pulse_width_generator.sv
// Programmable pulse-train source: num_pulses pulses of width_ms high with gap_ms low between.
// Latency: pulse_out rises one edge after start; backpressure: none, start is ignored outside IDLE.
module pulse_width_generator #(
    parameter int CLKS_PER_MS = 50000,
    parameter int MS_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [MS_W-1:0] width_ms,
    input  logic [MS_W-1:0] gap_ms,
    input  logic [7:0]      num_pulses,
    output logic            pulse_out,
    output logic            ready,
    output logic            busy,
    output logic            done_tick,
    output logic [7:0]      pulse_count
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLKS_PER_MS - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [MS_W-1:0] MS_ONE    = MS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [MS_W-1:0] width_q, width_d;
    logic [MS_W-1:0] gap_q, gap_d;
    logic [7:0]      num_q, num_d;
    logic [7:0]      count_q, count_d;
    logic            pulse_q, pulse_d;
    logic            ms_wrap;

    assign ms_wrap = (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        width_d = width_q;
        gap_d   = gap_q;
        num_d   = num_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    width_d = width_ms;
                    gap_d   = gap_ms;
                    num_d   = num_pulses;
                    count_d = 8'd0;
                    presc_d = '0;
                    ms_d    = '0;
                    if (width_ms == '0 || num_pulses == 8'd0) state_d = S_DONE;
                    else                                      state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ms_wrap && ms_q == width_q - MS_ONE) begin
                    count_d = count_q + 8'd1;
                    presc_d = '0;
                    ms_d    = '0;
                    if (count_q + 8'd1 == num_q) state_d = S_DONE;
                    else                         state_d = S_GAP;
                end else if (ms_wrap) begin
                    presc_d = '0;
                    ms_d    = ms_q + MS_ONE;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            S_GAP: begin
                // a zero gap still spends one low cycle so pulses stay separable
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0 || (ms_wrap && ms_q == gap_q - MS_ONE)) begin
                    presc_d = '0;
                    ms_d    = '0;
                    state_d = S_HIGH;
                end else if (ms_wrap) begin
                    presc_d = '0;
                    ms_d    = ms_q + MS_ONE;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pulse_d = (state_d == S_HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            width_q <= '0;
            gap_q   <= '0;
            num_q   <= 8'd0;
            count_q <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            num_q   <= num_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign ready       = (state_q == S_IDLE);
    assign busy        = (state_q == S_HIGH) || (state_q == S_GAP);
    assign done_tick   = (state_q == S_DONE);
    assign pulse_count = count_q;

endmodule
